// File: rtl/adc_emulator_if.sv
// Serial ADC wires: chip select and clock from the controller, serial data back to it.
interface adc_emulator_if;
    logic cs;
    logic sclk;
    logic data_out;

    modport master (output cs, output sclk, input data_out);
    modport slave  (input cs, input sclk, output data_out);
endinterface

// File: rtl/adc_emulator.sv
// Emulates a 12-bit serial ADC: on cs fall latches sample_data and shifts it out
// MSB first behind leading zeros, one bit per synchronized sclk falling edge.
module adc_emulator #(
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned LEAD_ZEROS  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_emulator_if.slave        spi,
    input  logic [DATA_BITS-1:0] sample_data,
    output logic                 busy,
    output logic                 sample_taken,
    output logic                 frame_done,
    output logic                 frame_error
);
    localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync;
    logic                    cs_hist, sclk_hist;
    logic [SYNC_STAGES:0]    primed;
    logic                    edge_en, cs_fall, cs_rise, sclk_fall;
    logic [FRAME_BITS-1:0]   shreg, shreg_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    data_out_q, data_out_d;
    logic                    busy_d, taken_d, done_d, error_d;

    // Synchronizers plus history flops; idle-high reset values.
    // primed gates edge detection until the chain holds real pin values, so a cs
    // already low at reset release is not mistaken for a fresh fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            cs_hist   <= 1'b1;
            sclk_hist <= 1'b1;
            primed    <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign edge_en   = primed[SYNC_STAGES];
    assign cs_fall   = edge_en &  cs_hist   & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise   = edge_en & ~cs_hist   &  cs_sync[SYNC_STAGES-1];
    assign sclk_fall = edge_en &  sclk_hist & ~sclk_sync[SYNC_STAGES-1];

    // Next state and next registered outputs; cs edges take priority over sclk.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        taken_d = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shreg_d = FRAME_BITS'(sample_data);
                    cnt_d   = '0;
                    taken_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    shreg_d = {shreg[FRAME_BITS-2:0], 1'b0};
                    cnt_d   = cnt + CNT_W'(1);
                    if (cnt_d == CNT_W'(FRAME_BITS)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        data_out_d = (state_d == SHIFT) ? shreg_d[FRAME_BITS-1] : 1'b0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            data_out_q   <= 1'b0;
            busy         <= 1'b0;
            sample_taken <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_d;
            shreg        <= shreg_d;
            cnt          <= cnt_d;
            data_out_q   <= data_out_d;
            busy         <= busy_d;
            sample_taken <= taken_d;
            frame_done   <= done_d;
            frame_error  <= error_d;
        end
    end

    assign spi.data_out = data_out_q;

endmodule

// File: tb/tb_adc_emulator.sv
// Bench for adc_emulator: acts as the ADC controller, reads words on sclk rises and
// scores each frame end against the word latched when cs fell.
module tb_adc_emulator;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_data;
    logic        busy, sample_taken, frame_done, frame_error;

    adc_emulator_if spi();

    adc_emulator #(.DATA_BITS(12), .LEAD_ZEROS(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi),
        .sample_data  (sample_data),
        .busy         (busy),
        .sample_taken (sample_taken),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_error;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          n_taken = 0;
    int          n_done = 0;
    int          n_err = 0;
    logic [15:0] mon_word = '0;
    logic        prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Controller side of the wire: a bit is read on every sclk rise while cs is low.
    always @(posedge spi.sclk) begin
        if (spi.cs === 1'b0) mon_word = {mon_word[14:0], spi.data_out};
    end

    // Scoreboard monitor: pops one expectation per frame end.
    always @(negedge clk) begin
        exp_t e;
        logic any;
        any = !rst && (sample_taken || frame_done || frame_error);
        if (any) begin
            check("pulse_onehot", 32'($countones({sample_taken, frame_done, frame_error})), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (sample_taken) begin
                n_taken++;
                check("busy_with_taken", 32'(busy), 32'd1);
            end
            if (frame_done) n_done++;
            if (frame_error) n_err++;
            if (frame_done || frame_error) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_end: done=%0b error=%0b, required no frame end", frame_done, frame_error);
                end else begin
                    e = exp_q.pop_front();
                    check("end_kind_error", 32'(frame_error), 32'(e.is_error));
                    if (frame_done) check("word", 32'(mon_word), 32'(e.word));
                end
            end
        end
        prev_pulse = any;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [11:0] val, input bit abort);
        sample_data = val;
        spi.cs = 1'b0;
        exp_q.push_back('{is_error: abort, word: {4'h0, val}});
        cycles(4 + int'($urandom_range(0, 3)));
    endtask

    task automatic sclk_pulses(input int n, input int hi, input int lo);
        repeat (n) begin
            spi.sclk = 1'b1;
            cycles(hi);
            spi.sclk = 1'b0;
            cycles(lo);
        end
    endtask

    task automatic end_frame();
        spi.cs = 1'b1;
        cycles(6);
    endtask

    task automatic run_frame(input logic [11:0] val, input int nfalls, input bit abort,
                             input int hi, input int lo);
        int t0, d0, e0, first;
        t0 = n_taken;
        d0 = n_done;
        e0 = n_err;
        start_frame(val, abort);
        sample_data = 12'($urandom);
        first = (nfalls < 3) ? nfalls : 3;
        sclk_pulses(first, hi, lo);
        sample_data = ~val;
        if (nfalls > 3) sclk_pulses(nfalls - 3, hi, lo);
        if (!abort) begin
            check("done_data_out", 32'(spi.data_out), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
        end
        end_frame();
        check("taken_count", 32'(n_taken - t0), 32'd1);
        check("done_count", 32'(n_done - d0), abort ? 32'd0 : 32'd1);
        check("error_count", 32'(n_err - e0), abort ? 32'd1 : 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data_out", 32'(spi.data_out), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, e0, nf;
        bit ab;
        rst = 1'b1;
        spi.cs = 1'b1;
        spi.sclk = 1'b0;
        sample_data = '0;
        cycles(3);
        check("rst_data_out", 32'(spi.data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_taken", 32'(sample_taken), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        cycles(5);

        // Nominal frame at 12 MHz / 100 kHz, then extremes.
        run_frame(12'hABC, 16, 1'b0, 60, 60);
        run_frame(12'hFFF, 16, 1'b0, 6, 6);
        run_frame(12'h000, 16, 1'b0, 6, 6);

        // Early abort, then recovery; then a sample change mid-frame (0x555 -> 0xAAA).
        run_frame(12'h5A5, 5, 1'b1, 5, 5);
        run_frame(12'h123, 16, 1'b0, 5, 5);
        run_frame(12'h555, 16, 1'b0, 7, 7);

        // Reset mid-frame after 8 falls.
        start_frame(12'h9A6, 1'b0);
        sclk_pulses(8, 5, 5);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_data_out", 32'(spi.data_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pulses", 32'({sample_taken, frame_done, frame_error}), 32'd0);
        cycles(2);
        rst = 1'b0;
        t0 = n_taken;
        d0 = n_done;
        e0 = n_err;
        sclk_pulses(4, 5, 5);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_data_out", 32'(spi.data_out), 32'd0);
        check("postrst_pulses", 32'((n_taken - t0) + (n_done - d0) + (n_err - e0)), 32'd0);
        end_frame();
        run_frame(12'h3C3, 16, 1'b0, 5, 5);

        // sclk activity with cs high, then cs and sclk falling together.
        t0 = n_taken;
        d0 = n_done;
        spi.sclk = 1'b1;
        cycles(5);
        check("cs_high_ignored", 32'(n_taken - t0), 32'd0);
        spi.cs = 1'b0;
        spi.sclk = 1'b0;
        sample_data = 12'h6E1;
        exp_q.push_back('{is_error: 1'b0, word: 16'h06E1});
        cycles(3);
        check("coincident_data_out", 32'(spi.data_out), 32'd0);
        check("coincident_busy", 32'(busy), 32'd1);
        sample_data = 12'h000;
        cycles(2);
        sclk_pulses(16, 5, 5);
        end_frame();
        check("coincident_taken", 32'(n_taken - t0), 32'd1);
        check("coincident_done", 32'(n_done - d0), 32'd1);

        // 17 falls: the extra one must be ignored.
        run_frame(12'h2D7, 17, 1'b0, 5, 5);

        for (int i = 0; i < 20; i++) begin
            ab = ($urandom_range(0, 3) == 0);
            nf = ab ? int'($urandom_range(1, 15)) : 16;
            run_frame(12'($urandom), nf, ab, int'($urandom_range(4, 9)), int'($urandom_range(4, 9)));
        end

        cycles(10);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/adc_emulator.md
# adc_emulator

SPI responder that emulates a 12-bit serial ADC (16-clock frame, 4 leading zeros, MSB first) so the ADC controller and the comparator/LED chain can be exercised on the board without a physical converter. It watches the `cs` and `sclk` lines driven by the ADC controller, oversamples them in the system clock domain, and shifts out a parallel sample supplied by test logic (switches, counter or ROM) on `data_out`. It sits on the far end of the same `cs`/`sclk`/serial-data wires the ADC controller drives and reads.

## Interface
- `DATA_BITS`, 12, sample width shifted out after the leading zeros
- `LEAD_ZEROS`, 4, zero bits sent before the sample MSB
- `SYNC_STAGES`, 2, synchronizer flops on `cs` and `sclk` (minimum 2)

- `clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `cs`  input  1  chip select from the ADC controller, active low, asynchronous to `clk`
- `sclk`  input  1  serial clock from the ADC controller, asynchronous to `clk`
- `sample_data`  input  DATA_BITS  value to be returned in the next frame
- `data_out`  output  1  serial data to the controller's `data_in`
- `busy`  output  1  high while a frame is in progress (SHIFT or DONE)
- `sample_taken`  output  1  one-cycle pulse when `sample_data` is latched
- `frame_done`  output  1  one-cycle pulse after the last bit is shifted out
- `frame_error`  output  1  one-cycle pulse when `cs` rises before the frame completes

## Operation
- Frame length F = LEAD_ZEROS + DATA_BITS (16 by default); bit counter is $clog2(F+1) bits wide.
- `cs` and `sclk` each pass through SYNC_STAGES flops, then one history flop; edges are detected by comparing the last sync stage against the history flop.
- Sync and history flops reset to 1 (both lines idle high).
- States:
  - IDLE: `data_out`=0, `busy`=0. On `cs` fall: load shift register with {LEAD_ZEROS zeros, `sample_data`}, clear counter, pulse `sample_taken`, go to SHIFT.
  - SHIFT: `data_out` = shift register MSB. On each `sclk` falling edge: shift left (zero fill), counter+1. Falling edge bringing counter to F: go to DONE, pulse `frame_done`, `data_out`=0.
  - DONE: `data_out`=0; further `sclk` edges ignored. On `cs` rise: go to IDLE.
- `cs` rise in SHIFT: pulse `frame_error`, go to IDLE, `data_out`=0.
- `sclk` rising edges never change state; the controller samples on them.
- Priority in one cycle: `cs` edge over `sclk` edge. `cs` fall + `sclk` fall: load only, no shift. `cs` rise + `sclk` fall in SHIFT: abort (`frame_error`), no shift, no `frame_done`.
- `sample_data` is read only in the load cycle; changes during a frame do not affect the frame.
- `sclk` activity while `cs` is high is ignored.
- Output pulses are mutually exclusive and never longer than one cycle.

## Timing
- Reset: state IDLE; `data_out`, `busy`, `sample_taken`, `frame_done`, `frame_error` all 0; shift register and counter 0.
- Latency: a pin transition first captured at `clk` edge e0 takes effect on outputs at edge e0+SYNC_STAGES (2 with defaults).
- `busy` rises in the same cycle as `sample_taken`; falls the cycle after the `cs` rise is acted on.
- `data_out` is registered; no combinational path from inputs.
- Correct operation requires each `sclk` high and low phase ≥ SYNC_STAGES+2 `clk` periods and `cs`-fall-to-first-`sclk`-fall ≥ SYNC_STAGES+2 periods; at 12 MHz/100 kHz each phase is 60 periods.
- Reset asserted mid-frame: outputs drop to reset values immediately (asynchronously); no pulse issued. After release the block waits for a fresh `cs` fall.

## Test plan
- Nominal frame, `sample_data`=0xABC, 12 MHz clk, 100 kHz sclk, 16 clocks -> controller reads 0x0ABC; `sample_taken` once at start, `frame_done` once after 16th fall, `frame_error` never.
- Extremes: frames with 0xFFF then 0x000 -> 16-bit words 0x0FFF and 0x0000; leading four bits always 0; `data_out`=0 between frames.
- Early abort: `cs` raised after 5 `sclk` falls -> `frame_error` one pulse, no `frame_done`, `busy`=0, next frame with 0x123 reads 0x0123.
- Mid-frame change: `sample_data` 0x555 at `cs` fall, switched to 0xAAA after 3 `sclk` falls -> word read is 0x0555.
- Reset mid-frame after 8 falls -> all outputs 0 immediately; `sclk` pulses with `cs` still low produce no outputs; new frame with 0x3C3 reads 0x03C3.
- Coincident edges: `cs` fall and `sclk` fall in the same sampled cycle -> load only, `data_out`=0, counter 0; 17 `sclk` falls in a frame -> 16th gives `frame_done`, 17th ignored, `data_out` stays 0.
